// File: rtl/mux_accumulate_ctrl.sv
// Sequencer and signed accumulator around the 32x4 operand mux: steps the select
// through operands 0..3, sums them, and hands the result downstream over valid/ready.
//
// state | meaning
// IDLE  | waiting for start; sel parked at 0
// ACCUM | one operand per edge is added while sel walks 0..3
// DONE  | result presented on sum_out/sum_valid until sum_ready
module mux_accumulate_ctrl #(
  parameter int WIDTH = 32,
  parameter int N_OPS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic [1:0]       sel,
  input  logic [WIDTH-1:0] mux_out,
  output logic             busy,
  output logic [WIDTH-1:0] sum_out,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [1:0] SEL_LAST = 2'(N_OPS - 1);

  state_t           state, state_nxt;
  logic [1:0]       sel_nxt;
  logic [WIDTH-1:0] acc, acc_nxt, sum_nxt, step_sum;
  logic             valid_nxt, ovf_nxt, step_ovf;

  // Overflow only when both addends share a sign that the result does not.
  assign step_sum = acc + mux_out;
  assign step_ovf = (acc[WIDTH-1] == mux_out[WIDTH-1]) &&
                    (step_sum[WIDTH-1] != acc[WIDTH-1]);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sel       <= '0;
      acc       <= '0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      acc       <= acc_nxt;
      sum_out   <= sum_nxt;
      sum_valid <= valid_nxt;
      overflow  <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    acc_nxt   = acc;
    sum_nxt   = sum_out;
    valid_nxt = sum_valid;
    ovf_nxt   = overflow;
    case (state)
      IDLE: begin
        sel_nxt = '0;
        if (start) begin
          state_nxt = ACCUM;
          acc_nxt   = '0;
          ovf_nxt   = 1'b0;
        end
      end
      ACCUM: begin
        acc_nxt = step_sum;
        ovf_nxt = overflow | step_ovf;
        if (sel == SEL_LAST) begin
          sum_nxt   = step_sum;
          valid_nxt = 1'b1;
          sel_nxt   = '0;
          state_nxt = DONE;
        end else begin
          sel_nxt = sel + 2'd1;
        end
      end
      DONE: begin
        sel_nxt = '0;
        if (sum_valid && sum_ready) begin
          valid_nxt = 1'b0;
          if (start) begin
            state_nxt = ACCUM;
            acc_nxt   = '0;
            ovf_nxt   = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        sel_nxt   = '0;
        valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_accumulate_ctrl.sv
// Self-checking bench for mux_accumulate_ctrl: a behavioural 4:1 mux feeds the DUT and
// expected {overflow,sum} pairs are queued at start and popped when sum_valid appears.
module tb_mux_accumulate_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  sel;
  logic [31:0] mux_out;
  logic        busy;
  logic [31:0] sum_out;
  logic        sum_valid;
  logic        sum_ready = 1'b0;
  logic        overflow;

  logic [31:0] ins [4];
  logic [32:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign mux_out = ins[sel];

  mux_accumulate_ctrl #(.WIDTH(32), .N_OPS(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .sel(sel), .mux_out(mux_out),
    .busy(busy), .sum_out(sum_out), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .overflow(overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] model(input logic [31:0] a, b, c, d);
    logic [127:0] ops;
    logic [31:0]  s, x, r;
    logic         o;
    ops = {d, c, b, a};
    s = '0;
    o = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x = ops[i*32 +: 32];
      r = s + x;
      if (s[31] == x[31] && r[31] != s[31]) o = 1'b1;
      s = r;
    end
    return {o, s};
  endfunction

  task automatic set_ins(input logic [31:0] a, b, c, d);
    ins[0] = a; ins[1] = b; ins[2] = c; ins[3] = d;
  endtask

  // Waits for sum_valid (bounded), then pops and compares one result.
  task automatic wait_result(input string name, input int exp_lat);
    logic [32:0] e;
    int n = 0;
    while (!sum_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!sum_valid) begin
      errors++;
      $display("FAIL %s_timeout: sum_valid=%0b after %0d cycles, required 1", name, sum_valid, n);
    end else begin
      e = exp_q.pop_front();
      if (exp_lat >= 0) begin
        checks++;
        if (n !== exp_lat) begin
          errors++;
          $display("FAIL %s_latency: got %0d cycles, required %0d", name, n, exp_lat);
        end
      end
      checks++;
      if (sum_out !== e[31:0]) begin
        errors++;
        $display("FAIL %s_sum: got %h, required %h", name, sum_out, e[31:0]);
      end
      checks++;
      if (overflow !== e[32]) begin
        errors++;
        $display("FAIL %s_ovf: got %0b, required %0b", name, overflow, e[32]);
      end
    end
  endtask

  task automatic run_accum(input string name, input logic [31:0] a, b, c, d);
    set_ins(a, b, c, d);
    exp_q.push_back(model(a, b, c, d));
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_result(name, 4);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_ins(0, 0, 0, 0);
    #12;
    checks++;
    if ({sel, busy, sum_valid, overflow} !== 5'b0 || sum_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: sel=%0d busy=%0b valid=%0b ovf=%0b sum=%h, required all 0",
               sel, busy, sum_valid, overflow, sum_out);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    sum_ready = 1'b1;
    set_ins(0, 1, 2, 3);
    exp_q.push_back(model(0, 1, 2, 3));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sel !== 2'(i) || busy !== 1'b1 || sum_valid !== 1'b0) begin
        errors++;
        $display("FAIL basic_sel%0d: sel=%0d busy=%0b valid=%0b, required sel=%0d busy=1 valid=0",
                 i, sel, busy, sum_valid, i);
      end
      if (i < 3) tick();
    end
    tick();
    wait_result("basic", 0);
    checks++;
    if (sel !== 2'd0) begin
      errors++;
      $display("FAIL basic_done_sel: got %0d, required 0", sel);
    end
    tick();
    checks++;
    if (sum_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: valid=%0b busy=%0b, required 0 0", sum_valid, busy);
    end
  endtask

  task automatic test_overflow();
    sum_ready = 1'b1;
    run_accum("ovf_pos", 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0);
    tick();
    run_accum("ovf_none", 32'hFFFF_8080, 32'h80, 32'd0, 32'd0);
    tick();
    run_accum("ovf_neg", 32'h8000_0000, 32'hFFFF_FFFF, 32'd5, 32'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      run_accum("rand", $urandom, $urandom, $urandom, $urandom);
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    sum_ready = 1'b0;
    run_accum("bp", 32'd0, 32'd1, 32'd2, 32'hFFFF_8080);
    held = sum_out;
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      tick();
      checks++;
      if (sum_out !== held || sum_valid !== 1'b1 || busy !== 1'b1 || sel !== 2'd0 ||
          overflow !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: sum=%h valid=%0b busy=%0b sel=%0d ovf=%0b, required %h 1 1 0 0",
                 i, sum_out, sum_valid, busy, sel, overflow, held);
      end
    end
    start = 1'b0;
    sum_ready = 1'b1;
    tick();
    checks++;
    if (sum_valid !== 1'b0 || busy !== 1'b0 || sum_out !== held) begin
      errors++;
      $display("FAIL bp_release: valid=%0b busy=%0b sum=%h, required 0 0 %h",
               sum_valid, busy, sum_out, held);
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] e;
    int results = 0;
    int last = 0;
    sum_ready = 1'b1;
    set_ins(1, 1, 1, 1);
    for (int k = 0; k < 3; k++) exp_q.push_back(model(1, 1, 1, 1));
    start = 1'b1;
    for (int cyc = 0; cyc < 40 && results < 3; cyc++) begin
      tick();
      if (sum_valid) begin
        results++;
        e = exp_q.pop_front();
        checks++;
        if (sum_out !== e[31:0] || overflow !== e[32]) begin
          errors++;
          $display("FAIL b2b_sum%0d: got %h/%0b, required %h/%0b",
                   results, sum_out, overflow, e[31:0], e[32]);
        end
        if (results > 1) begin
          checks++;
          if (cyc - last !== 5) begin
            errors++;
            $display("FAIL b2b_interval%0d: got %0d cycles, required 5", results, cyc - last);
          end
        end
        last = cyc;
        if (results == 3) start = 1'b0;
      end
    end
    checks++;
    if (results !== 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d results, required 3", results);
    end
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%0b, required 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    sum_ready = 1'b1;
    set_ins(32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    while (sel !== 2'd2 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (sel !== 2'd2 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: sel=%0d ovf=%0b, required 2 1", sel, overflow);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (sel !== 2'd0 || sum_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 ||
        sum_out !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_async: sel=%0d valid=%0b busy=%0b ovf=%0b sum=%h, required all 0",
               sel, sum_valid, busy, overflow, sum_out);
    end
    #10;
    reset_n = 1'b1;
    tick();
    run_accum("rstmid_after", 32'd0, 32'd1, 32'd2, 32'd3);
    tick();
  endtask

  task automatic test_start_in_accum();
    int extra = 0;
    sum_ready = 1'b1;
    set_ins(0, 1, 2, 3);
    exp_q.push_back(model(0, 1, 2, 3));
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (sel !== 2'd1) begin
      errors++;
      $display("FAIL sia_sel: got %0d, required 1", sel);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_result("sia", -1);
    tick();
    for (int i = 0; i < 12; i++) begin
      tick();
      if (sum_valid || busy) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL sia_extra: got %0d active cycles, required 0", extra);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_start_in_accum();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL queue_empty: %0d results outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_accumulate_ctrl.md
Name: mux_accumulate_ctrl

Overview:
- Sequencing and accumulation stage wrapped around the 32x4 operand multiplexer (mux32x4).
- Drives the mux select through inputs 0..3 and consumes the mux output each cycle, forming a 32-bit signed sum of the four operands (neuron partial-sum gather).
- Presents the result on a valid/ready output handshake to the downstream neuron/activation stage.

Parameters:
- WIDTH, 32, data width of mux output and sum; must match mux32x4.
- N_OPS, 4, operands per accumulation; fixed at 4 (2-bit select); other values are unsupported.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request a new 4-operand accumulation; sampled on rising clk.
- sel  output  2  select driven to mux32x4 (registered).
- mux_out  input  WIDTH  mux32x4 output; combinational function of sel and the mux inputs.
- busy  output  1  high in ACCUM and DONE.
- sum_out  output  WIDTH  accumulated two's-complement sum; stable while sum_valid=1.
- sum_valid  output  1  result available.
- sum_ready  input  1  downstream accepts result.
- overflow  output  1  signed overflow occurred during this accumulation; valid with sum_valid.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, sel=0, acc=0, sum_out=0, sum_valid=0, overflow=0, busy=0. Takes effect immediately, including mid-accumulation; any partial sum is discarded and no result is emitted.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - sel=0.
  - start=1 at an edge -> ACCUM, acc=0, overflow=0, sel=0.
- ACCUM:
  - Each edge: acc <= acc + mux_out, using WIDTH-bit wrap-around arithmetic.
  - overflow <= overflow | signed_ovf. signed_ovf means both operands have the same sign and the result sign differs.
  - sel increments by 1 on every edge except the edge that samples sel=3.
  - On the edge sampling sel=3: sum_out <= final sum, sum_valid <= 1, sel <= 0, state -> DONE.
- Latency: start sampled at edge k. Operands 0..3 are sampled at edges k+1..k+4. sum_valid is high after edge k+4. Throughput is 1 result per 5 cycles when start is back-to-back.
- DONE:
  - sum_out, overflow and sum_valid hold while sum_ready=0 (unbounded backpressure).
  - sum_valid=1 & sum_ready=1 at an edge -> sum_valid <= 0. If start=1 on that same edge, go to ACCUM (acc, overflow cleared); otherwise go to IDLE.
- start while in ACCUM is ignored, with no restart and no queuing. start while in DONE without a handshake on that edge is also ignored.
- sum_ready while sum_valid=0 is ignored.
- Mux inputs must be stable from edge k+1 through edge k+4. The block does not register them.
- sum_out is written only on DONE entry. It retains the last result through IDLE.

Test Plan:
- Mux inputs in0..3=0,1,2,3, start pulse, sum_ready=1 -> sel steps 0,1,2,3 on consecutive cycles; sum_valid high 4 cycles after the start edge; sum_out=6, overflow=0; back to IDLE next edge.
- Inputs 0x7FFFFFFF,1,0,0 -> sum_out=0x80000000, overflow=1. Inputs 0xFFFF8080,0x80,0,0 -> sum_out=0xFFFF8100, overflow=0.
- Backpressure: inputs 0,1,2,0xFFFF8080, sum_ready=0 for 10 cycles after sum_valid -> sum_out=0xFFFF8083 held stable, busy=1, sel=0; sum_valid drops one edge after sum_ready=1.
- Back-to-back: start held high with sum_ready=1, inputs 1,1,1,1 -> sum_valid pulses every 5 cycles with sum_out=4 each time; sel never stalls beyond the DONE cycle.
- Reset mid-operation: assert reset_n=0 asynchronously while sel=2 -> sel, sum_valid, busy and overflow go to 0 immediately without waiting for clk; after release, a fresh start with inputs 0,1,2,3 yields 6.
- start pulsed while in ACCUM (sel=1) -> ignored; exactly one result (6) produced; no second sum_valid without a new start.
